// File: rtl/game_pkg.sv
// Shared definitions for the rhythm-game lane logic.
// Holds the judgment encodings, the lane judge FSM state encoding,
// the default timing windows and the score/combo widths.
package game_pkg;

    // Judgment code as presented on JUDGE; 2'b11 is never produced.
    typedef enum logic [1:0] {
        J_MISS    = 2'b00,
        J_GOOD    = 2'b01,
        J_PERFECT = 2'b10
    } judge_t;

    // IDLE: nothing pending. EARLY: push seen, waiting for the note.
    // LATE: note pending, waiting for the push.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_EARLY = 2'b01,
        S_LATE  = 2'b10
    } state_t;

    // Default windows are in cycles at 100 MHz (25 ms / 75 ms).
    localparam int DEF_PERFECT_WIN = 2500000;
    localparam int DEF_GOOD_WIN    = 7500000;
    localparam int DEF_CNT_W       = 24;

    localparam int SCORE_W = 16;
    localparam int COMBO_W = 10;

endpackage

// File: rtl/judge_score_accum.sv
// Saturating score / combo accumulator for one lane.
// Ports:
//   CLK, RST        clock and synchronous active-high reset
//   JV, JCODE       judgment strobe and its code (MISS/GOOD/PERFECT)
//   SCORE           accumulated score, saturates at all-ones
//   COMBO           consecutive hits, saturates at all-ones, cleared on MISS
//   MAX_COMBO       highest COMBO reached since reset
module judge_score_accum
    import game_pkg::*;
#(
    parameter int PERFECT_PTS = 3,
    parameter int GOOD_PTS    = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               JV,
    input  judge_t             JCODE,
    output logic [SCORE_W-1:0] SCORE,
    output logic [COMBO_W-1:0] COMBO,
    output logic [COMBO_W-1:0] MAX_COMBO
);

    function automatic logic [SCORE_W-1:0] sat_add_score(
        input logic [SCORE_W-1:0] a,
        input logic [SCORE_W-1:0] b
    );
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

    function automatic logic [COMBO_W-1:0] sat_inc_combo(
        input logic [COMBO_W-1:0] a
    );
        return (a == '1) ? a : a + COMBO_W'(1);
    endfunction

    logic [SCORE_W-1:0] pts;
    logic [COMBO_W-1:0] combo_n;
    logic               hit;

    always_comb begin
        pts = '0;
        case (JCODE)
            J_PERFECT: pts = SCORE_W'(PERFECT_PTS);
            J_GOOD:    pts = SCORE_W'(GOOD_PTS);
            default:   pts = '0;
        endcase
        hit     = (JCODE != J_MISS);
        combo_n = sat_inc_combo(COMBO);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            SCORE     <= '0;
            COMBO     <= '0;
            MAX_COMBO <= '0;
        end else if (JV) begin
            SCORE <= sat_add_score(SCORE, pts);
            if (hit) begin
                COMBO <= combo_n;
                if (combo_n > MAX_COMBO)
                    MAX_COMBO <= combo_n;
            end else begin
                COMBO <= '0;
            end
        end
    end

endmodule

// File: rtl/note_judge.sv
// Per-lane timing judge. Measures the cycle offset between the rising edge
// of the stretched push level and the note-arrival pulse and classifies each
// note as PERFECT, GOOD or MISS; score and combo are kept downstream of the
// decision in judge_score_accum.
// Ports:
//   CLK, RST        clock and synchronous active-high reset
//   PUSH            stretched button level
//   NOTE            one-cycle note-arrival pulse
//   JUDGE_VALID     one-cycle strobe, registered, the cycle after the decision
//   JUDGE           judgment code, holds its last value between strobes
//   SCORE, COMBO, MAX_COMBO   lane score state, updated with JUDGE_VALID
module note_judge
    import game_pkg::*;
#(
    parameter int PERFECT_WIN = DEF_PERFECT_WIN,
    parameter int GOOD_WIN    = DEF_GOOD_WIN,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PERFECT_PTS = 3,
    parameter int GOOD_PTS    = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               PUSH,
    input  logic               NOTE,
    output logic               JUDGE_VALID,
    output logic [1:0]         JUDGE,
    output logic [SCORE_W-1:0] SCORE,
    output logic [COMBO_W-1:0] COMBO,
    output logic [COMBO_W-1:0] MAX_COMBO
);

    localparam logic [CNT_W-1:0] P_LIM = CNT_W'(PERFECT_WIN);
    localparam logic [CNT_W-1:0] G_LIM = CNT_W'(GOOD_WIN);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    function automatic judge_t classify(input logic [CNT_W-1:0] off);
        return (off <= P_LIM) ? J_PERFECT : J_GOOD;
    endfunction

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             push_d;
    logic             rise;
    logic             dec_vld_p0;
    judge_t           dec_code_p0;

    // push_d resets high so a button held through reset is not a press.
    assign rise = PUSH & ~push_d;

    // Decision stage (p0): next state, offset counter and judgment.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        dec_vld_p0  = 1'b0;
        dec_code_p0 = J_MISS;
        case (state)
            S_IDLE: begin
                if (rise && NOTE) begin
                    dec_vld_p0  = 1'b1;
                    dec_code_p0 = J_PERFECT;
                end else if (rise) begin
                    state_n = S_EARLY;
                    cnt_n   = ONE;
                end else if (NOTE) begin
                    state_n = S_LATE;
                    cnt_n   = ONE;
                end
            end
            S_EARLY: begin
                // A note on the last window cycle still wins over the timeout.
                if (NOTE) begin
                    dec_vld_p0  = 1'b1;
                    dec_code_p0 = classify(cnt);
                    state_n     = S_IDLE;
                    cnt_n       = '0;
                end else if (cnt == G_LIM) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            S_LATE: begin
                if (rise) begin
                    // The press settles the pending note; a note arriving in the
                    // same cycle becomes the new pending note.
                    dec_vld_p0  = 1'b1;
                    dec_code_p0 = classify(cnt);
                    if (NOTE) begin
                        cnt_n = ONE;
                    end else begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end
                end else if (NOTE) begin
                    dec_vld_p0  = 1'b1;
                    dec_code_p0 = J_MISS;
                    cnt_n       = ONE;
                end else if (cnt == G_LIM) begin
                    dec_vld_p0  = 1'b1;
                    dec_code_p0 = J_MISS;
                    state_n     = S_IDLE;
                    cnt_n       = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Output stage (p1): registered judgment strobe and code.
    always_ff @(posedge CLK) begin
        if (RST) begin
            push_d      <= 1'b1;
            state       <= S_IDLE;
            cnt         <= '0;
            JUDGE_VALID <= 1'b0;
            JUDGE       <= J_MISS;
        end else begin
            push_d      <= PUSH;
            state       <= state_n;
            cnt         <= cnt_n;
            JUDGE_VALID <= dec_vld_p0;
            if (dec_vld_p0)
                JUDGE <= dec_code_p0;
        end
    end

    judge_score_accum #(
        .PERFECT_PTS(PERFECT_PTS),
        .GOOD_PTS   (GOOD_PTS)
    ) u_accum (
        .CLK      (CLK),
        .RST      (RST),
        .JV       (dec_vld_p0),
        .JCODE    (dec_code_p0),
        .SCORE    (SCORE),
        .COMBO    (COMBO),
        .MAX_COMBO(MAX_COMBO)
    );

endmodule

// File: tb/tb_note_judge.sv
// Directed bench for note_judge with PERFECT_WIN=4, GOOD_WIN=10.
// Expected judgments (code, score, combo, max combo, arrival cycle) are
// pushed to a queue as stimulus is driven and checked when JUDGE_VALID fires.
module tb_note_judge;

    logic        CLK = 1'b0;
    logic        RST;
    logic        PUSH;
    logic        NOTE;
    logic        JUDGE_VALID;
    logic [1:0]  JUDGE;
    logic [15:0] SCORE;
    logic [9:0]  COMBO;
    logic [9:0]  MAX_COMBO;

    localparam logic [1:0] MISS    = 2'b00;
    localparam logic [1:0] GOOD    = 2'b01;
    localparam logic [1:0] PERFECT = 2'b10;

    note_judge #(
        .PERFECT_WIN(4),
        .GOOD_WIN   (10)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PUSH       (PUSH),
        .NOTE       (NOTE),
        .JUDGE_VALID(JUDGE_VALID),
        .JUDGE      (JUDGE),
        .SCORE      (SCORE),
        .COMBO      (COMBO),
        .MAX_COMBO  (MAX_COMBO)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  code;
        logic [15:0] score;
        logic [9:0]  combo;
        logic [9:0]  maxc;
        int          at;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   m_score = 0;
    int   m_combo = 0;
    int   m_max   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference score model: fold one judgment in, queue the expected result.
    task automatic expect_j(input logic [1:0] code, input int at);
        exp_t e;
        if (code == PERFECT) m_score += 3;
        else if (code == GOOD) m_score += 1;
        if (m_score > 65535) m_score = 65535;
        if (code == MISS) m_combo = 0;
        else if (m_combo < 1023) m_combo++;
        if (m_combo > m_max) m_max = m_combo;
        e.code  = code;
        e.score = 16'(m_score);
        e.combo = 10'(m_combo);
        e.maxc  = 10'(m_max);
        e.at    = at;
        q.push_back(e);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (JUDGE_VALID === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 32'(JUDGE_VALID), 32'd0);
            end else begin
                e = q.pop_front();
                chk("judge",     32'(JUDGE),     32'(e.code));
                chk("score",     32'(SCORE),     32'(e.score));
                chk("combo",     32'(COMBO),     32'(e.combo));
                chk("max_combo", 32'(MAX_COMBO), 32'(e.maxc));
                chk("latency",   32'(cyc),       32'(e.at));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    int n;

    initial begin
        RST = 1'b1; PUSH = 1'b1; NOTE = 1'b0;
        idle(3);
        chk("rst_valid", 32'(JUDGE_VALID), 32'd0);
        chk("rst_judge", 32'(JUDGE),       32'd0);
        chk("rst_score", 32'(SCORE),       32'd0);
        chk("rst_combo", 32'(COMBO),       32'd0);
        chk("rst_max",   32'(MAX_COMBO),   32'd0);

        // PUSH held across reset release: no press, so the note times out.
        RST = 1'b0;
        idle(2);
        NOTE = 1'b1; tick(); n = cyc; NOTE = 1'b0; PUSH = 1'b0;
        expect_j(MISS, n + 10);
        idle(12);

        // NOTE then press 3 cycles later -> PERFECT.
        NOTE = 1'b1; tick(); n = cyc; NOTE = 1'b0;
        idle(2);
        PUSH = 1'b1; tick(); expect_j(PERFECT, n + 3); PUSH = 1'b0;
        idle(3);
        chk("judge_hold", 32'(JUDGE),       32'(PERFECT));
        chk("valid_low",  32'(JUDGE_VALID), 32'd0);

        // Press then NOTE 7 cycles later -> GOOD.
        PUSH = 1'b1; tick(); n = cyc; PUSH = 1'b0;
        idle(6);
        NOTE = 1'b1; tick(); expect_j(GOOD, n + 7); NOTE = 1'b0;
        idle(3);

        // Press then NOTE 11 cycles later: empty tap, then the note misses.
        PUSH = 1'b1; tick(); n = cyc; PUSH = 1'b0;
        idle(10);
        NOTE = 1'b1; tick(); expect_j(MISS, n + 21); NOTE = 1'b0;
        idle(12);

        // Two notes 5 apart, press 2 after the second.
        NOTE = 1'b1; tick(); n = cyc; NOTE = 1'b0;
        idle(4);
        NOTE = 1'b1; tick(); expect_j(MISS, n + 5); NOTE = 1'b0;
        idle(1);
        PUSH = 1'b1; tick(); expect_j(PERFECT, n + 7); PUSH = 1'b0;
        idle(3);

        // Press and note in the same cycle -> PERFECT.
        PUSH = 1'b1; NOTE = 1'b1; tick(); expect_j(PERFECT, cyc);
        PUSH = 1'b0; NOTE = 1'b0;
        idle(3);

        // Press on the last LATE window cycle -> GOOD, not MISS.
        NOTE = 1'b1; tick(); n = cyc; NOTE = 1'b0;
        idle(9);
        PUSH = 1'b1; tick(); expect_j(GOOD, n + 10); PUSH = 1'b0;
        idle(3);

        // Note on the last EARLY window cycle -> GOOD, not an empty tap.
        PUSH = 1'b1; tick(); n = cyc; PUSH = 1'b0;
        idle(9);
        NOTE = 1'b1; tick(); expect_j(GOOD, n + 10); NOTE = 1'b0;
        idle(3);

        // In LATE, press and new note together: judge old, new one pends.
        NOTE = 1'b1; tick(); n = cyc; NOTE = 1'b0;
        idle(2);
        PUSH = 1'b1; NOTE = 1'b1; tick();
        expect_j(PERFECT, n + 3);
        expect_j(MISS, n + 13);
        PUSH = 1'b0; NOTE = 1'b0;
        idle(14);

        // Reset while a note is pending: no MISS, everything cleared.
        NOTE = 1'b1; tick(); NOTE = 1'b0;
        idle(3);
        RST = 1'b1; tick();
        chk("mid_rst_valid", 32'(JUDGE_VALID), 32'd0);
        chk("mid_rst_judge", 32'(JUDGE),       32'd0);
        chk("mid_rst_score", 32'(SCORE),       32'd0);
        chk("mid_rst_combo", 32'(COMBO),       32'd0);
        chk("mid_rst_max",   32'(MAX_COMBO),   32'd0);
        m_score = 0; m_combo = 0; m_max = 0;
        RST = 1'b0;
        idle(15);

        // Score saturation: 21846 PERFECTs.
        for (int i = 0; i < 21846; i++) begin
            PUSH = 1'b1; NOTE = 1'b1; tick(); expect_j(PERFECT, cyc);
            PUSH = 1'b0; NOTE = 1'b0; tick();
        end
        idle(2);
        chk("score_sat", 32'(SCORE), 32'hFFFF);

        // Clear the combo, then 1030 consecutive hits.
        NOTE = 1'b1; tick(); n = cyc; NOTE = 1'b0;
        expect_j(MISS, n + 10);
        idle(12);
        for (int i = 0; i < 1030; i++) begin
            PUSH = 1'b1; NOTE = 1'b1; tick(); expect_j(PERFECT, cyc);
            PUSH = 1'b0; NOTE = 1'b0; tick();
        end
        idle(2);
        chk("score_hold", 32'(SCORE),     32'hFFFF);
        chk("combo_sat",  32'(COMBO),     32'd1023);
        chk("max_sat",    32'(MAX_COMBO), 32'd1023);

        for (int i = 0; i < 30 && q.size() != 0; i++) tick();
        chk("drain", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/note_judge.md
# note_judge

Per-lane timing judge for the rhythm game. Consumes the stretched `push` level from the lane's button stretcher and a one-cycle note-arrival pulse from the chart sequencer, and classifies each note as PERFECT, GOOD or MISS from the cycle offset between the push rising edge and the note arrival. Keeps the lane's score, current combo and max combo for the display/score stage downstream.

## Interface
- `PERFECT_WIN`, default 2500000: max |offset| in cycles for PERFECT (25 ms @ 100 MHz).
- `GOOD_WIN`, default 7500000: max |offset| in cycles for GOOD; must satisfy PERFECT_WIN <= GOOD_WIN < 2^CNT_W.
- `CNT_W`, default 24: offset counter width.
- `PERFECT_PTS`, default 3: score added on PERFECT.
- `GOOD_PTS`, default 1: score added on GOOD.
- `CLK`  in  1  system clock.
- `RST`  in  1  synchronous, active-high reset.
- `PUSH`  in  1  stretched button level (high while pressed or held by the stretcher).
- `NOTE`  in  1  one-cycle pulse: a note crosses the judgment line this cycle.
- `JUDGE_VALID`  out  1  one-cycle pulse: a judgment is presented on `JUDGE`.
- `JUDGE`  out  2  2'b00 MISS, 2'b01 GOOD, 2'b10 PERFECT; 2'b11 unused.
- `SCORE`  out  16  accumulated score, saturating.
- `COMBO`  out  10  consecutive hits, saturating.
- `MAX_COMBO`  out  10  highest COMBO since reset.

## Operation
- Edge detect: `push_d` register; `rise = PUSH & ~push_d`. `push_d` resets to 1, so PUSH held high through reset gives no rise.
- States: IDLE, EARLY (push seen, awaiting note), LATE (note pending, awaiting push).
- Counter `cnt` (CNT_W bits) holds the offset in cycles; loaded with 1 on entry to EARLY/LATE, +1 per cycle in state.
- IDLE: rise & NOTE same cycle -> PERFECT (offset 0), stay IDLE. rise only -> EARLY. NOTE only -> LATE.
- EARLY: NOTE -> PERFECT if cnt <= PERFECT_WIN else GOOD, -> IDLE. No NOTE at cnt == GOOD_WIN -> empty tap, no judgment, -> IDLE. Further rises ignored.
- LATE: rise -> PERFECT if cnt <= PERFECT_WIN else GOOD, -> IDLE. No rise at cnt == GOOD_WIN -> MISS, -> IDLE.
- LATE with NOTE (no rise): pending note judged MISS; stay LATE, cnt reloaded to 1 for the new note.
- LATE with rise & NOTE same cycle: rise judges the pending note; new note enters LATE with cnt = 1.
- Simultaneous boundary: in EARLY, NOTE at cnt == GOOD_WIN is GOOD, not timeout; in LATE, rise at cnt == GOOD_WIN is GOOD, not MISS.
- Accumulation on each judgment: PERFECT adds PERFECT_PTS, GOOD adds GOOD_PTS, MISS adds 0; SCORE saturates at 16'hFFFF.
- COMBO +1 on PERFECT/GOOD (saturates at 1023) and cleared on MISS. MAX_COMBO <= max(MAX_COMBO, new COMBO).
- Empty taps do not affect SCORE or COMBO.

## Timing
- All outputs registered. Reset values: JUDGE_VALID 0, JUDGE 2'b00, SCORE 0, COMBO 0, MAX_COMBO 0, state IDLE, cnt 0.
- Latency: JUDGE_VALID/JUDGE assert the cycle after the deciding cycle (rise, NOTE or timeout). SCORE/COMBO/MAX_COMBO update in that same cycle.
- JUDGE holds its last value between pulses. At most one judgment per cycle.
- RST mid-operation: pending note discarded without a MISS. All state and outputs return to reset values on the next edge.

## Structure
- Shared package (`game_pkg`): JUDGE encodings (MISS/GOOD/PERFECT), state encoding, default window constants, score/combo widths.
- One natural sub-module: `judge_score_accum`. Takes the judgment pulse and code, holds the saturating SCORE/COMBO/MAX_COMBO registers.
- The FSM, counter and edge detect live in `note_judge`.

## Test plan
Bench uses PERFECT_WIN=4, GOOD_WIN=10.
- NOTE then rise 3 cycles later -> one cycle after the rise: JUDGE_VALID=1, JUDGE=PERFECT, SCORE=3, COMBO=1.
- Rise then NOTE 7 cycles later -> GOOD, SCORE +1, COMBO +1. NOTE 11 cycles after the rise -> no judgment for the tap; the note then MISSes 10 cycles later.
- NOTE with no push -> JUDGE=MISS exactly 11 cycles after NOTE, COMBO cleared to 0, SCORE unchanged.
- Two NOTEs 5 cycles apart, rise 2 cycles after the second -> MISS on the second NOTE's cycle+1, then PERFECT.
- Boundaries: rise & NOTE same cycle -> PERFECT. Rise at LATE cnt=10 -> GOOD (not MISS). PUSH high across RST release -> no rise, no judgment. RST asserted in LATE -> no MISS, all outputs 0.
- Saturation: preload via 21846 PERFECTs -> SCORE=16'hFFFF and holds; 1030 consecutive hits -> COMBO=MAX_COMBO=1023.
